// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the voice allocator and the note_player bank.
package voice_allocator_pkg;

   localparam int unsigned NOTE_W_DEFAULT = 6;
   localparam int unsigned DUR_W_DEFAULT  = 6;

   // One-hot stereo side encodings shared with note_player.
   localparam logic [1:0] STEREO_LEFT  = 2'b01;
   localparam logic [1:0] STEREO_RIGHT = 2'b10;
   localparam logic [1:0] STEREO_BOTH  = 2'b11;

   typedef enum logic [0:0] {
      StIdle    = 1'b0,
      StAdvance = 1'b1
   } state_t;

endpackage

// File: rtl/voice_select.sv
// Lowest-index free voice finder: one-hot grant plus an any-free flag.
module voice_select #(
   parameter int unsigned NUM_VOICES = 3
) (
   input  logic [NUM_VOICES-1:0] busy,
   output logic [NUM_VOICES-1:0] grant,
   output logic                  any_free
);

   // Scan upward and grant the first zero bit only.
   always_comb begin
      grant    = '0;
      any_free = 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         if (!busy[i] && !any_free) begin
            grant[i] = 1'b1;
            any_free = 1'b1;
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Schedules note and time-advance requests onto a bank of note_player voices.
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 3,
   parameter int unsigned NOTE_W     = NOTE_W_DEFAULT,
   parameter int unsigned DUR_W      = DUR_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  play_enable,
   input  logic                  beat,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_is_advance,
   input  logic [NOTE_W-1:0]     in_note,
   input  logic [DUR_W-1:0]      in_duration,
   input  logic [1:0]            in_stereo,
   output logic [NOTE_W-1:0]     note_to_load,
   output logic [DUR_W-1:0]      duration_to_load,
   output logic [1:0]            stereo_side_to_load,
   output logic [NUM_VOICES-1:0] load_new_note,
   input  logic [NUM_VOICES-1:0] done_with_note,
   output logic [NUM_VOICES-1:0] voice_busy,
   output logic                  advancing
);

   state_t               state_q;
   logic [DUR_W-1:0]     adv_cnt_q;
   logic [NUM_VOICES-1:0] grant;
   logic                 any_free;
   logic                 accept;
   logic                 load_note;
   logic                 start_adv;
   logic                 count_beat;

   voice_select #(
      .NUM_VOICES (NUM_VOICES)
   ) u_voice_select (
      .busy     (voice_busy),
      .grant    (grant),
      .any_free (any_free)
   );

   // Handshake and request decode; zero-length notes and advances are accepted but do nothing.
   always_comb begin
      in_ready   = (state_q == StIdle) && play_enable && (in_is_advance || any_free);
      accept     = in_valid && in_ready;
      load_note  = accept && !in_is_advance && (in_duration != '0);
      start_adv  = accept && in_is_advance && (in_duration != '0);
      count_beat = beat && play_enable;
      advancing  = (state_q == StAdvance);
   end

   // Advance FSM: holds off new requests until the programmed number of beats has elapsed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         adv_cnt_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_adv) begin
                  state_q   <= StAdvance;
                  adv_cnt_q <= in_duration;
               end
            end
            StAdvance: begin
               if (count_beat) begin
                  adv_cnt_q <= adv_cnt_q - DUR_W'(1);
                  if (adv_cnt_q == DUR_W'(1)) begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Load bus: payload captured on a real note load, pulse lasts one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         note_to_load        <= '0;
         duration_to_load    <= '0;
         stereo_side_to_load <= '0;
         load_new_note       <= '0;
      end else begin
         load_new_note <= {NUM_VOICES{load_note}} & grant;
         if (load_note) begin
            note_to_load        <= in_note;
            duration_to_load    <= in_duration;
            stereo_side_to_load <= in_stereo;
         end
      end
   end

   // Occupancy: clear on done, then set on grant so a same-cycle set wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         voice_busy <= '0;
      end else begin
         voice_busy <= (voice_busy & ~done_with_note) | ({NUM_VOICES{load_note}} & grant);
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with NUM_VOICES = 3.
module tb_voice_allocator;

   localparam int unsigned NV = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          play_enable;
   logic          beat;
   logic          in_valid;
   logic          in_ready;
   logic          in_is_advance;
   logic [5:0]    in_note;
   logic [5:0]    in_duration;
   logic [1:0]    in_stereo;
   logic [5:0]    note_to_load;
   logic [5:0]    duration_to_load;
   logic [1:0]    stereo_side_to_load;
   logic [NV-1:0] load_new_note;
   logic [NV-1:0] done_with_note;
   logic [NV-1:0] voice_busy;
   logic          advancing;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   voice_allocator #(
      .NUM_VOICES (NV),
      .NOTE_W     (6),
      .DUR_W      (6)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .play_enable         (play_enable),
      .beat                (beat),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_is_advance       (in_is_advance),
      .in_note             (in_note),
      .in_duration         (in_duration),
      .in_stereo           (in_stereo),
      .note_to_load        (note_to_load),
      .duration_to_load    (duration_to_load),
      .stereo_side_to_load (stereo_side_to_load),
      .load_new_note       (load_new_note),
      .done_with_note      (done_with_note),
      .voice_busy          (voice_busy),
      .advancing           (advancing)
   );

   typedef struct {
      logic          pe;
      logic          bt;
      logic          valid;
      logic          adv;
      logic [5:0]    note;
      logic [5:0]    dur;
      logic [1:0]    st;
      logic [NV-1:0] done;
      logic          exp_ready;
      logic [NV-1:0] exp_load;
      logic [NV-1:0] exp_busy;
      logic          exp_adv;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic pe, input logic bt, input logic valid, input logic adv,
                        input logic [5:0] note, input logic [5:0] dur, input logic [1:0] st,
                        input logic [NV-1:0] done);
      play_enable    = pe;
      beat           = bt;
      in_valid       = valid;
      in_is_advance  = adv;
      in_note        = note;
      in_duration    = dur;
      in_stereo      = st;
      done_with_note = done;
   endtask

   // Sample combinational outputs mid-cycle, then advance one clock and settle.
   task automatic mid;
      #4;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  rem;
      bit  done_flag;

      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd20, 6'd4, 2'b01, 3'b000, 1'b1, 3'b001, 3'b001, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd20, 6'd4, 2'b01, 3'b000, 1'b1, 3'b010, 3'b011, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd20, 6'd4, 2'b01, 3'b000, 1'b1, 3'b100, 3'b111, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd33, 6'd5, 2'b10, 3'b000, 1'b0, 3'b000, 3'b111, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd33, 6'd5, 2'b10, 3'b010, 1'b0, 3'b000, 3'b101, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd33, 6'd5, 2'b10, 3'b000, 1'b1, 3'b010, 3'b111, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0, 2'b00, 3'b101, 1'b0, 3'b000, 3'b010, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd5,  6'd0, 2'b01, 3'b000, 1'b1, 3'b000, 3'b010, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd0,  6'd0, 2'b00, 3'b000, 1'b1, 3'b000, 3'b010, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd7,  6'd3, 2'b11, 3'b000, 1'b1, 3'b001, 3'b011, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd9,  6'd2, 2'b01, 3'b010, 1'b1, 3'b100, 3'b101, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd9,  6'd2, 2'b01, 3'b001, 1'b0, 3'b000, 3'b100, 1'b0};

      // Reset and check the cleared state.
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00, 3'b000);
      tick();
      tick();
      chk("rst_load", 32'(load_new_note), 32'd0);
      chk("rst_busy", 32'(voice_busy), 32'd0);
      chk("rst_adv", 32'(advancing), 32'd0);
      chk("rst_note", 32'(note_to_load), 32'd0);
      chk("rst_dur", 32'(duration_to_load), 32'd0);
      chk("rst_stereo", 32'(stereo_side_to_load), 32'd0);
      reset = 1'b0;

      // Table: allocation, stall, release, dropped notes, zero advance, done+alloc, pause.
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].pe, vecs[i].bt, vecs[i].valid, vecs[i].adv, vecs[i].note, vecs[i].dur,
               vecs[i].st, vecs[i].done);
         mid();
         chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
         tick();
         chk($sformatf("v%0d_load", i), 32'(load_new_note), 32'(vecs[i].exp_load));
         chk($sformatf("v%0d_busy", i), 32'(voice_busy), 32'(vecs[i].exp_busy));
         chk($sformatf("v%0d_adv", i), 32'(advancing), 32'(vecs[i].exp_adv));
         if (vecs[i].exp_load != '0) begin
            chk($sformatf("v%0d_note", i), 32'(note_to_load), 32'(vecs[i].note));
            chk($sformatf("v%0d_dur", i), 32'(duration_to_load), 32'(vecs[i].dur));
            chk($sformatf("v%0d_st", i), 32'(stereo_side_to_load), 32'(vecs[i].st));
         end
      end

      // Advance D=3 with a beat on the acceptance cycle (not counted), beats every 5 cycles.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 6'd3, 2'b00, 3'b000);
      mid();
      chk("adv3_accept_ready", 32'(in_ready), 32'd1);
      tick();
      chk("adv3_advancing", 32'(advancing), 32'd1);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd40, 6'd6, 2'b01, 3'b000);
      rem = 3;
      done_flag = 1'b0;
      for (int i = 0; i < 40; i++) begin
         beat = (i % 5 == 4);
         mid();
         if (rem == 0) begin
            chk("adv3_ready_after", 32'(in_ready), 32'd1);
            chk("adv3_idle_after", 32'(advancing), 32'd0);
            tick();
            chk("adv3_load", 32'(load_new_note), 32'b001);
            chk("adv3_note", 32'(note_to_load), 32'd40);
            done_flag = 1'b1;
            break;
         end
         chk("adv3_ready_low", 32'(in_ready), 32'd0);
         chk("adv3_adv_high", 32'(advancing), 32'd1);
         tick();
         if (beat) rem--;
      end
      if (!done_flag) chk("adv3_timeout", 32'd1, 32'd0);
      // busy now 101

      // Advance D=3: one beat, pause 20 cycles with beats and a done, then 2 more beats.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 6'd3, 2'b00, 3'b000);
      tick();
      chk("pause_adv_start", 32'(advancing), 32'd1);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd41, 6'd2, 2'b10, 3'b000);
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, (i % 5 == 2), 1'b1, 1'b0, 6'd41, 6'd2, 2'b10, (i == 7) ? 3'b100 : 3'b000);
         mid();
         chk("pause_ready", 32'(in_ready), 32'd0);
         tick();
         chk("pause_load", 32'(load_new_note), 32'd0);
         chk("pause_adv", 32'(advancing), 32'd1);
      end
      chk("pause_busy_tracks_done", 32'(voice_busy), 32'b001);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd41, 6'd2, 2'b10, 3'b000);
      tick();
      chk("resume_adv0", 32'(advancing), 32'd1);
      beat = 1'b1;
      tick();
      chk("resume_adv1", 32'(advancing), 32'd1);
      beat = 1'b0;
      tick();
      chk("resume_adv2", 32'(advancing), 32'd1);
      beat = 1'b1;
      mid();
      chk("resume_ready_low", 32'(in_ready), 32'd0);
      tick();
      chk("resume_adv_done", 32'(advancing), 32'd0);
      beat = 1'b0;
      mid();
      chk("resume_ready", 32'(in_ready), 32'd1);
      tick();
      chk("resume_load", 32'(load_new_note), 32'b010);
      chk("resume_busy", 32'(voice_busy), 32'b011);

      // Reset in the middle of an advance with voice_busy = 011.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 6'd5, 2'b00, 3'b000);
      tick();
      chk("rstadv_advancing", 32'(advancing), 32'd1);
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00, 3'b000);
      tick();
      reset = 1'b0;
      beat  = 1'b0;
      chk("rstadv_adv", 32'(advancing), 32'd0);
      chk("rstadv_busy", 32'(voice_busy), 32'd0);
      chk("rstadv_load", 32'(load_new_note), 32'd0);
      chk("rstadv_note", 32'(note_to_load), 32'd0);
      chk("rstadv_ready_pe1", 32'(in_ready), 32'd1);
      play_enable = 1'b0;
      #1;
      chk("rstadv_ready_pe0", 32'(in_ready), 32'd0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd12, 6'd1, 2'b11, 3'b000);
      tick();
      chk("rstadv_first_load", 32'(load_new_note), 32'b001);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00, 3'b000);
      tick();
      chk("rstadv_pulse_one_cycle", 32'(load_new_note), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
